// File: rtl/vga_pkg.sv
// Shared VGA timing for the 800x600@72 mode, RGB444 field layout and the
// sync/blank bundle type used between the scan controller and its delay line.
package vga_pkg;

   localparam int CNT_W   = 11;
   localparam int COORD_W = 10;
   localparam int RGB_W   = 12;

   localparam int VGA_H_ACTIVE = 800;
   localparam int VGA_H_FP     = 56;
   localparam int VGA_H_SYNC   = 120;
   localparam int VGA_H_BP     = 64;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_ACTIVE = 600;
   localparam int VGA_V_FP     = 37;
   localparam int VGA_V_SYNC   = 6;
   localparam int VGA_V_BP     = 23;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Sync windows are half-open: [start, end)
   localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
   localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic video;
      logic hs;
      logic vs;
   } vga_ctl_t;

   function automatic logic sync_level(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] start,
                                       input logic [CNT_W-1:0] stop,
                                       input logic             pol);
      return (cnt >= start && cnt < stop) ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_pix_delay.sv
// PIPE-deep shift register for the {video, hs, vs} bundle, advancing only on
// pixel ticks so the pin-side syncs line up with the ROM read latency.
module vga_pix_delay #(
   parameter int         PIPE    = 1,
   parameter logic [2:0] RST_VAL = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic [2:0] din,
   output logic [2:0] dout
);

   logic [2:0] stage_q [PIPE];
   logic [2:0] stage_d [PIPE];

   always_comb begin
      stage_d = stage_q;
      if (pix_en) begin
         stage_d[0] = din;
         for (int i = 1; i < PIPE; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[PIPE-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan initiator: pixel-enable divider, h/v counters, col/row addressing
// for the scene ROMs, and latency-matched sync/RGB pin drivers.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int PIPE     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] rgb_in,
   output logic        pix_en,
   output logic [9:0]  col,
   output logic [9:0]  row,
   output logic        video_on,
   output logic        frame_end,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               pix_en_q, pix_en_d;
   logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic               video_on_q, video_on_d;
   logic               frame_end_q, frame_end_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;

   logic     visible;
   vga_ctl_t ctl_raw;
   vga_ctl_t ctl_dly;

   assign visible = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

   always_comb begin
      ctl_raw.video = visible;
      ctl_raw.hs    = sync_level(h_cnt_q, HS_ON, HS_OFF, HS_POL);
      ctl_raw.vs    = sync_level(v_cnt_q, VS_ON, VS_OFF, VS_POL);
   end

   vga_pix_delay #(
      .PIPE    (PIPE),
      .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
   ) u_pix_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_en (pix_en_q),
      .din    (ctl_raw),
      .dout   (ctl_dly)
   );

   // Everything below pix_en moves only on a pixel tick; frame_end alone is a
   // single-clk pulse and so defaults low every cycle.
   always_comb begin
      div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      pix_en_d    = (div_cnt_q == DIV_LAST);
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      col_d       = col_q;
      row_d       = row_q;
      video_on_d  = video_on_q;
      frame_end_d = 1'b0;
      hs_d        = hs_q;
      vs_d        = vs_q;
      rgb_d       = rgb_q;
      if (pix_en_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
         video_on_d  = visible;
         col_d       = visible ? h_cnt_q[COORD_W-1:0] : '0;
         row_d       = visible ? v_cnt_q[COORD_W-1:0] : '0;
         frame_end_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_ACT - 1'b1);
         hs_d        = ctl_dly.hs;
         vs_d        = ctl_dly.vs;
         rgb_d       = ctl_dly.video ? rgb_in : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         pix_en_q    <= 1'b0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         col_q       <= '0;
         row_q       <= '0;
         video_on_q  <= 1'b0;
         frame_end_q <= 1'b0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         rgb_q       <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         pix_en_q    <= pix_en_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         video_on_q  <= video_on_d;
         frame_end_q <= frame_end_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         rgb_q       <= rgb_d;
      end
   end

   assign pix_en    = pix_en_q;
   assign col       = col_q;
   assign row       = row_q;
   assign video_on  = video_on_q;
   assign frame_end = frame_end_q;
   assign hs        = hs_q;
   assign vs        = vs_q;
   assign vga_r     = rgb_q[R_MSB:R_LSB];
   assign vga_g     = rgb_q[G_MSB:G_LSB];
   assign vga_b     = rgb_q[B_MSB:B_LSB];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a shrunken 30x17 raster so whole
// frames fit in a short run; a second instance covers CLK_DIV=1, PIPE=3.
module tb_vga_scan_ctrl;

   localparam int HA = 16, HF = 4, HSW = 6, HB = 4;
   localparam int VA = 10, VF = 2, VSW = 3, VB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic [11:0] rgbInA = 12'h000;
   logic [11:0] rgbInB;
   logic        pixEnA, videoOnA, frameEndA, hsA, vsA;
   logic [9:0]  colA, rowA;
   logic [3:0]  vgaRA, vgaGA, vgaBA;
   logic        pixEnB, videoOnB, frameEndB, hsB, vsB;
   logic [9:0]  colB, rowB;
   logic [3:0]  vgaRB, vgaGB, vgaBB;

   assign rgbInB = 12'hFFF;

   // Scene ROM model: registered every system clock, returning white in blanking
   always @(posedge clk) begin
      rgbInA <= videoOnA ? {colA[3:0], rowA[3:0], 4'hA} : 12'hFFF;
   end

   vga_scan_ctrl #(
      .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(1)
   ) dutA (
      .clk(clk), .rst_n(rst_n), .rgb_in(rgbInA), .pix_en(pixEnA),
      .col(colA), .row(rowA), .video_on(videoOnA), .frame_end(frameEndA),
      .hs(hsA), .vs(vsA), .vga_r(vgaRA), .vga_g(vgaGA), .vga_b(vgaBA)
   );

   vga_scan_ctrl #(
      .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(3)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .rgb_in(rgbInB), .pix_en(pixEnB),
      .col(colB), .row(rowB), .video_on(videoOnB), .frame_end(frameEndB),
      .hs(hsB), .vs(vsB), .vga_r(vgaRB), .vga_g(vgaGB), .vga_b(vgaBB)
   );

   int compared = 0;
   int mismatched = 0;
   int clkCnt = 0, pixCnt = 0, feCnt = 0, feTick = -1;
   logic lastPix = 1'b0;
   int bVonRise = -1, bVonFall = -1, bRgbRise = -1, bHsRise = -1, bPixLow = 0;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One system clock: sample at the falling edge and update event bookkeeping
   task automatic stepClk();
      @(negedge clk);
      clkCnt++;
      if (frameEndA) begin
         feCnt++;
         if (feTick < 0) feTick = pixCnt;
      end
      lastPix = pixEnA;
      if (pixEnA) pixCnt++;
      if (!pixEnB) bPixLow++;
      if (bVonRise < 0 && videoOnB) bVonRise = clkCnt;
      if (bVonRise >= 0 && bVonFall < 0 && !videoOnB) bVonFall = clkCnt;
      if (bRgbRise < 0 && {vgaRB, vgaGB, vgaBB} != 12'h000) bRgbRise = clkCnt;
      if (bHsRise < 0 && hsB) bHsRise = clkCnt;
   endtask

   // Advance to the falling edge just before pixel edge number 'target'
   task automatic runTo(input int target);
      int guard = 5000;
      while (!(lastPix && pixCnt - 1 == target) && guard > 0) begin
         stepClk();
         guard--;
      end
      if (guard == 0) checkOutput("runTo_bound", pixCnt - 1, target);
   endtask

   task automatic applyStimulus(input logic rstVal);
      rst_n = rstVal;
      if (rstVal) begin
         clkCnt = 0; pixCnt = 0; feCnt = 0; feTick = -1; lastPix = 1'b0;
      end
   endtask

   int vonLine, hsLine = 0, hsFrame = 0, vsFrame = 0, firstHs = -1, firstVs = -1;

   initial begin
      applyStimulus(1'b0);
      repeat (5) @(negedge clk);
      checkOutput("rst_pix_en", pixEnA, 0);
      checkOutput("rst_hs", hsA, 0);
      checkOutput("rst_vs", vsA, 0);
      checkOutput("rst_rgb", {vgaRA, vgaGA, vgaBA}, 0);
      checkOutput("rst_video_on", videoOnA, 0);
      checkOutput("rst_hs_b", hsB, 0);

      applyStimulus(1'b1);
      stepClk(); checkOutput("pix_en_clk1", pixEnA, 0);
      stepClk(); checkOutput("pix_en_clk2", pixEnA, 1);
      stepClk(); checkOutput("pix_en_clk3", pixEnA, 0);
      stepClk(); checkOutput("pix_en_clk4", pixEnA, 1);
      checkOutput("s1_col", colA, 0);
      checkOutput("s1_video_on", videoOnA, 1);
      checkOutput("s1_rgb", {vgaRA, vgaGA, vgaBA}, 0);
      vonLine = int'(videoOnA);

      // Sample s shows the counter position s-1 on col/row and s-2 on the pins
      for (int s = 2; s <= 520; s++) begin
         runTo(s);
         if (s <= 30 && videoOnA) vonLine++;
         if (s <= 31 && hsA) hsLine++;
         if (s <= 511 && hsA) hsFrame++;
         if (s <= 511 && vsA) vsFrame++;
         if (hsA && firstHs < 0) firstHs = s;
         if (vsA && firstVs < 0) firstVs = s;
         case (s)
            2:   checkOutput("pin_px0_0", {vgaRA, vgaGA, vgaBA}, 12'h00A);
            6:   checkOutput("col_5", colA, 5);
            17:  begin
                    checkOutput("hblank_video_on", videoOnA, 0);
                    checkOutput("hblank_col", colA, 0);
                 end
            22:  checkOutput("blank_rgb_white_in", {vgaRA, vgaGA, vgaBA}, 12'h000);
            96:  begin
                    checkOutput("col_at_5_3", colA, 5);
                    checkOutput("row_at_5_3", rowA, 3);
                 end
            97:  checkOutput("pin_px5_3", {vgaRA, vgaGA, vgaBA}, 12'h53A);
            301: begin
                    checkOutput("vblank_video_on", videoOnA, 0);
                    checkOutput("vblank_row", rowA, 0);
                 end
            511: begin
                    checkOutput("frame2_col", colA, 0);
                    checkOutput("frame2_row", rowA, 0);
                    checkOutput("frame2_video_on", videoOnA, 1);
                 end
            512: checkOutput("frame2_pin_px0_0", {vgaRA, vgaGA, vgaBA}, 12'h00A);
            default: ;
         endcase
      end

      checkOutput("line_video_ticks", vonLine, 16);
      checkOutput("line_hs_ticks", hsLine, 6);
      checkOutput("first_hs_sample", firstHs, 22);
      checkOutput("frame_hs_ticks", hsFrame, 102);
      checkOutput("frame_vs_ticks", vsFrame, 90);
      checkOutput("first_vs_sample", firstVs, 362);
      checkOutput("frame_end_clks", feCnt, 1);
      checkOutput("frame_end_tick", feTick, 300);

      checkOutput("b_pix_en_low_clks", bPixLow, 0);
      checkOutput("b_video_on_rise_clk", bVonRise, 2);
      checkOutput("b_rgb_lag_clks", bRgbRise - bVonRise, 3);
      checkOutput("b_hs_lag_clks", bHsRise - bVonFall, 7);

      // Mid-frame reset at line 5, col 8 of the second frame
      runTo(669);
      #2;
      applyStimulus(1'b0);
      #1;
      checkOutput("midrst_col", colA, 0);
      checkOutput("midrst_video_on", videoOnA, 0);
      checkOutput("midrst_rgb", {vgaRA, vgaGA, vgaBA}, 0);
      checkOutput("midrst_pix_en", pixEnA, 0);
      checkOutput("midrst_hs", hsA, 0);
      repeat (3) @(negedge clk);
      applyStimulus(1'b1);
      runTo(1);
      checkOutput("restart_row", rowA, 0);
      checkOutput("restart_col", colA, 0);
      checkOutput("restart_video_on", videoOnA, 1);
      runTo(299);
      checkOutput("no_early_frame_end", feCnt, 0);
      runTo(302);
      checkOutput("restart_frame_end_tick", feTick, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- VGA scan initiator for the whole display path.
- Divides the system clock into a pixel enable and runs horizontal/vertical counters.
- Drives the col/row scan coordinates that every scene/sprite module uses to address its ROM.
- Samples the merged 12-bit pixel returned by those modules and drives hsync, vsync and the 4:4:4 RGB pins, with sync/blank delayed to match the ROM read latency.

Parameters:
- CLK_DIV, 2: system clocks per pixel (100 MHz to 50 MHz); must be >=1.
- H_ACTIVE, 800: visible pixels per line.
- H_FP, 56: horizontal front porch, in pixels.
- H_SYNC, 120: hsync width, in pixels.
- H_BP, 64: horizontal back porch; H_TOTAL = 1040.
- V_ACTIVE, 600: visible lines.
- V_FP, 37: vertical front porch, in lines.
- V_SYNC, 6: vsync width, in lines.
- V_BP, 23: vertical back porch; V_TOTAL = 666.
- HS_POL, 1: hsync active level.
- VS_POL, 1: vsync active level.
- PIPE, 1: pixel ticks between a col/row change and the matching rgb_in being valid (ROM latency); range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rgb_in  in  12  merged pixel {R[11:8],G[7:4],B[3:0]} for the col/row issued PIPE ticks earlier.
- pix_en  out  1  one-clk pulse per pixel.
- col  out  10  current x in active area; 0 in blanking.
- row  out  10  current y in active area; 0 in blanking.
- video_on  out  1  col/row denote a visible pixel (undelayed).
- frame_end  out  1  one-clk pulse on entering vertical blanking.
- hs  out  1  horizontal sync to the pin (delayed).
- vs  out  1  vertical sync to the pin (delayed).
- vga_r  out  4  red to the pin.
- vga_g  out  4  green to the pin.
- vga_b  out  4  blue to the pin.

Behaviour:
- Reset values (async, while rst_n=0):
  - div_cnt, h_cnt, v_cnt = 0.
  - pix_en, video_on, frame_end = 0; col = row = 0.
  - hs = ~HS_POL, vs = ~VS_POL; vga_r/g/b = 0.
  - Delay pipeline cleared to "blank, syncs inactive".
- Reset deassertion: counting restarts from h=0, v=0. Reset mid-frame discards the frame; no partial-line recovery.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high exactly in the clk cycle where div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly 1 after the first post-reset clk.
  - First pix_en occurs in clk cycle CLK_DIV after reset release.
- Counters (advance only when pix_en=1):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 together with the h wrap.
  - Counters are 11 bits; col/row are 10 bits.
- col/row/video_on:
  - Registered from the counter values, updated in the same pix_en cycle.
  - video_on = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - col = h_cnt[9:0] and row = v_cnt[9:0] when video_on; forced to 0 otherwise, so ROM addresses stay in range.
- Sync generation (raw, undelayed):
  - hs_raw = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (856..975), else ~HS_POL.
  - vs_raw = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (637..642), else ~VS_POL.
- frame_end: high for exactly one clk, on the pix_en where the counters move to h=0, v=V_ACTIVE. Game logic updates state on this pulse.
- Output alignment:
  - {video_on, hs_raw, vs_raw} pass through a PIPE-deep shift register clocked by pix_en.
  - On each pix_en, rgb_in is sampled. Outputs are {vga_r,vga_g,vga_b} = delayed video_on ? rgb_in : 12'h000.
  - hs and vs are the delayed raw syncs, registered in the same cycle.
  - Net result: pin timing equals counter timing shifted by exactly PIPE pixels.
- Between pix_en pulses, all outputs except pix_en and frame_end hold.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants (H/V active, porch, sync, totals) for the 800x600@72 mode.
  - RGB444 field positions.
  - Derived sync start/end values, so scene modules and this block agree on screen size.
- One natural sub-module: vga_pix_delay, a parameterised PIPE-deep, pix_en-gated shift register for the {blank, hs, vs} bundle.

Test Plan:
- Reset timing: rst_n=0 for 5 clks, then release.
  - pix_en first high in clk 2 after release, then every 2nd clk.
  - hs=0, vs=0 and RGB=0 during reset.
- Horizontal timing, over one line (2080 clks):
  - video_on high for 800 pix ticks with col 0..799, then col=0.
  - hs high for exactly 120 ticks, starting at pin tick 857 (856+PIPE).
  - Line period = 1040 ticks.
- Vertical timing, over one frame:
  - frame_end pulses once, one clk wide, at tick 600*1040.
  - vs high for 6 lines starting at line 637 (+1 pixel of delay).
  - Frame period = 692,640 ticks.
- Pixel alignment: rgb_in model = ROM returning {col[3:0],row[3:0],4'hA} one tick late.
  - The pin pixel at screen (5,3) is 12'h53A.
  - All blanking pixels are 12'h000 even when rgb_in=12'hFFF.
- Mid-frame reset: assert rst_n=0 at line 300, col 400 for 3 clks.
  - Outputs return to reset values immediately (async).
  - After release, row restarts at 0 and no frame_end occurs before tick 624,000.
- Parameter sweep: CLK_DIV=1, PIPE=3 → pix_en constant high; pin sync edges lag counter sync edges by exactly 3 clks.
